// File: rtl/fetch_sequencer.sv
// Fetch sequencer: produces the instruction fetch address. It handles sequential
// fetch, stalls, branches, interrupt entry through a one-edge VECTOR state, and
// return-from-interrupt. All state updates happen on the falling edge of clk,
// so the PC is stable around the rising edge used by instruction memory.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'd50,
  parameter logic [31:0] INT_VECTOR   = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic [15:0] branch_addr,
  input  logic        int_req,
  input  logic        rti,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        flush,
  output logic        int_ack,
  output logic [31:0] epc,
  output logic        in_isr
);

  typedef enum logic {
    RUN    = 1'b0,
    VECTOR = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic [31:0] epc_next;
  logic        fetch_valid_next;
  logic        flush_next;
  logic        int_ack_next;
  logic        in_isr_next;

  logic [31:0] branch_target;
  logic [31:0] pc_inc;
  logic        int_accept;

  assign branch_target = {{16{branch_addr[15]}}, branch_addr};
  assign pc_inc        = pc + 32'd1;
  // An interrupt is taken only when it cannot collide with a stall or an rti.
  // It must also not nest inside a running service routine.
  assign int_accept    = int_req && !in_isr && !stall && !rti;

  // Register all state and outputs on the falling edge. Reset overrides everything.
  always_ff @(negedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_VECTOR;
      epc         <= 32'd0;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      int_ack     <= 1'b0;
      in_isr      <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      epc         <= epc_next;
      fetch_valid <= fetch_valid_next;
      flush       <= flush_next;
      int_ack     <= int_ack_next;
      in_isr      <= in_isr_next;
    end
  end

  // Next-state logic: one action per edge in RUN, chosen by a fixed priority.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    epc_next         = epc;
    fetch_valid_next = fetch_valid;
    flush_next       = 1'b0;
    int_ack_next     = 1'b0;
    in_isr_next      = in_isr;

    unique case (state)
      RUN: begin
        if (int_accept) begin
          // When a branch arrives on the same edge, the return address is the branch target.
          epc_next         = branch ? branch_target : pc_inc;
          fetch_valid_next = 1'b0;
          flush_next       = 1'b1;
          state_next       = VECTOR;
        end else if (branch) begin
          pc_next          = branch_target;
          fetch_valid_next = 1'b1;
          flush_next       = 1'b1;
        end else if (rti && in_isr) begin
          pc_next          = epc;
          in_isr_next      = 1'b0;
          fetch_valid_next = 1'b1;
          flush_next       = 1'b1;
        end else if (stall) begin
          pc_next          = pc;
        end else begin
          pc_next          = pc_inc;
          fetch_valid_next = 1'b1;
        end
      end
      VECTOR: begin
        pc_next          = INT_VECTOR;
        int_ack_next     = 1'b1;
        in_isr_next      = 1'b1;
        fetch_valid_next = 1'b1;
        state_next       = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

endmodule
